// File: rtl/syn_pkg.sv
// Q16.16 types and arithmetic helpers shared across the SyNC neuron datapath.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package syn_pkg;

    typedef logic signed [31:0] q16_t;

    localparam q16_t ONE   = 32'sh0001_0000;
    localparam q16_t THIRD = 32'sh0000_5555;
    localparam q16_t Q_MAX = 32'sh7FFF_FFFF;
    localparam q16_t Q_MIN = 32'sh8000_0000;
    localparam int   NOUT  = 25;

    // Q16.16 product, saturated to the signed 32-bit range instead of wrapping.
    function automatic q16_t qmul(input q16_t a, input q16_t b);
        logic signed [63:0] ae;
        logic signed [63:0] be;
        logic signed [63:0] p;
        ae = {{32{a[31]}}, a};
        be = {{32{b[31]}}, b};
        p  = ae * be;
        p  = p >>> 16;
        if (p > 64'sh0000_0000_7FFF_FFFF) begin
            return Q_MAX;
        end
        if (p < -64'sh0000_0000_8000_0000) begin
            return Q_MIN;
        end
        return p[31:0];
    endfunction

    function automatic q16_t qclamp(input q16_t x, input q16_t lo, input q16_t hi);
        if (x < lo) begin
            return lo;
        end
        if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage

// File: rtl/syn_neuron_core_if.sv
// Control inputs and fp32 observables of the synapse/neuron core.
// Latency: none (wiring only).
// Backpressure: none; observables are continuously valid levels.
interface syn_neuron_core_if;

    logic        enable;
    logic        tp1;
    logic        td4;

    logic [31:0] Isyn1, RMx, WWx, Ax, Dx, RMtrx, Prelx, Inhx, Pxy;
    logic [31:0] Xn, Yn, Cx, Sx, Mx, Vpostx1, Wpostx1;
    logic [31:0] xs, tanhxs, ws, ys, zs, ps, qs, rs, RMout;

    modport master (
        output enable, tp1, td4,
        input  Isyn1, RMx, WWx, Ax, Dx, RMtrx, Prelx, Inhx, Pxy,
        input  Xn, Yn, Cx, Sx, Mx, Vpostx1, Wpostx1,
        input  xs, tanhxs, ws, ys, zs, ps, qs, rs, RMout
    );

    modport slave (
        input  enable, tp1, td4,
        output Isyn1, RMx, WWx, Ax, Dx, RMtrx, Prelx, Inhx, Pxy,
        output Xn, Yn, Cx, Sx, Mx, Vpostx1, Wpostx1,
        output xs, tanhxs, ws, ys, zs, ps, qs, rs, RMout
    );

endinterface

// File: rtl/fx2fp32.sv
// Signed Q16.16 to IEEE-754 binary32 converter, mantissa truncated toward zero.
// Latency: combinational.
// Backpressure: none.
module fx2fp32 import syn_pkg::*; (
    input  q16_t        q,
    output logic [31:0] f
);

    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  msb;

    always_comb begin
        f   = '0;
        mag = q[31] ? -q : q;
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                msb = 5'(i);
            end
        end
        // Leading one lands on bit 31; the hidden bit is dropped below.
        norm = mag << (5'd31 - msb);
        if (mag != '0) begin
            f = {q[31], 8'd111 + {3'b000, msb}, norm[30:8]};
        end
    end

endmodule

// File: rtl/syn_neuron_core.sv
// Plastic synapse (STP release, STDP traces) driving a two-variable neuron, stepped on a divided tick.
// Latency: state moves one model step per tick; observables are combinational from state.
// Backpressure: none; enable low freezes the model while spike edges keep being tracked.
module syn_neuron_core import syn_pkg::*; #(
    parameter int   TICK_DIV = 250,
    parameter q16_t A_INC    = 32'sh0000_4000,
    parameter q16_t D_INC    = 32'sh0000_2000,
    parameter q16_t C_INC    = 32'sh0000_8000,
    parameter q16_t P0       = 32'sh0000_4000,
    parameter q16_t W_INIT   = 32'sh0000_8000,
    parameter q16_t W_MAX    = 32'sh0001_0000,
    parameter int   TAU_SH   = 4
) (
    input  logic             clk_0_1ps,
    input  logic             reset,
    syn_neuron_core_if.slave bus
);

    localparam int HALF = TICK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] div_cnt;
    logic          clk;
    logic          wrap;
    logic          tick;

    assign wrap = (div_cnt == CW'(HALF - 1));
    assign tick = wrap & ~clk;

    always_ff @(posedge clk_0_1ps or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            clk     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            clk     <= ~clk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    logic tp1_prev;
    logic td4_prev;
    logic pre;
    logic post;

    assign pre  = bus.tp1 & ~tp1_prev;
    assign post = bus.td4 & ~td4_prev;

    // Edges are tracked even while disabled so stale levels never fire on re-enable.
    always_ff @(posedge clk_0_1ps or negedge reset) begin
        if (!reset) begin
            tp1_prev <= 1'b0;
            td4_prev <= 1'b0;
        end else if (tick) begin
            tp1_prev <= bus.tp1;
            td4_prev <= bus.td4;
        end
    end

    q16_t rmx, wwx, ax, dx, rmtrx, prelx, cx, sx, vpost, wpost, xn, yn, rmout;
    q16_t rel, isyn1, prel_sum, ww_sum;
    q16_t ys, zs, ps, qs, rs, ws, mx, inhx, pxy;

    always_comb begin
        rel      = pre ? qmul(prelx, rmx) : 32'sd0;
        isyn1    = qmul(wwx, sx);
        prel_sum = P0 + (cx >>> 2);
        ww_sum   = wwx + (post ? ax : 32'sd0) - (pre ? dx : 32'sd0);
    end

    always_ff @(posedge clk_0_1ps or negedge reset) begin
        if (!reset) begin
            rmx   <= ONE;
            rmout <= ONE;
            wwx   <= W_INIT;
            prelx <= P0;
            ax    <= '0;
            dx    <= '0;
            rmtrx <= '0;
            cx    <= '0;
            sx    <= '0;
            vpost <= '0;
            wpost <= '0;
            xn    <= '0;
            yn    <= '0;
        end else if (tick && bus.enable) begin
            rmtrx <= rel;
            rmx   <= rmx - rel + ((ONE - rmx) >>> TAU_SH);
            ax    <= ax - (ax >>> TAU_SH) + (pre  ? A_INC : 32'sd0);
            dx    <= dx - (dx >>> TAU_SH) + (post ? D_INC : 32'sd0);
            cx    <= cx - (cx >>> TAU_SH) + (pre  ? C_INC : 32'sd0);
            prelx <= (prel_sum > ONE) ? ONE : prel_sum;
            wwx   <= qclamp(ww_sum, 32'sd0, W_MAX);
            sx    <= sx - (sx >>> TAU_SH) + rel;
            vpost <= vpost + ((isyn1 - vpost - wpost) >>> TAU_SH);
            wpost <= wpost + ((vpost - wpost) >>> TAU_SH);
            xn    <= vpost;
            yn    <= wpost;
            rmout <= rmx;
        end
    end

    // Cubic tanh approximation x - x^3/3, clamped to [-1, 1].
    always_comb begin
        ys   = qmul(vpost, vpost);
        zs   = qmul(vpost, ys);
        ps   = qmul(zs, THIRD);
        qs   = vpost - ps;
        rs   = qclamp(qs, -ONE, ONE);
        ws   = ONE - qmul(rs, rs);
        mx   = qmul(cx, cx);
        inhx = sx >>> 1;
        pxy  = ax - dx;
    end

    q16_t        qv [NOUT];
    logic [31:0] fp [NOUT];

    assign qv[0]  = isyn1;
    assign qv[1]  = rmx;
    assign qv[2]  = wwx;
    assign qv[3]  = ax;
    assign qv[4]  = dx;
    assign qv[5]  = rmtrx;
    assign qv[6]  = prelx;
    assign qv[7]  = inhx;
    assign qv[8]  = pxy;
    assign qv[9]  = xn;
    assign qv[10] = yn;
    assign qv[11] = cx;
    assign qv[12] = sx;
    assign qv[13] = mx;
    assign qv[14] = vpost;
    assign qv[15] = wpost;
    assign qv[16] = vpost;
    assign qv[17] = rs;
    assign qv[18] = ws;
    assign qv[19] = ys;
    assign qv[20] = zs;
    assign qv[21] = ps;
    assign qv[22] = qs;
    assign qv[23] = rs;
    assign qv[24] = rmout;

    genvar g;
    generate
        for (g = 0; g < NOUT; g++) begin : g_cvt
            fx2fp32 u_cvt (
                .q (qv[g]),
                .f (fp[g])
            );
        end
    endgenerate

    assign bus.Isyn1   = fp[0];
    assign bus.RMx     = fp[1];
    assign bus.WWx     = fp[2];
    assign bus.Ax      = fp[3];
    assign bus.Dx      = fp[4];
    assign bus.RMtrx   = fp[5];
    assign bus.Prelx   = fp[6];
    assign bus.Inhx    = fp[7];
    assign bus.Pxy     = fp[8];
    assign bus.Xn      = fp[9];
    assign bus.Yn      = fp[10];
    assign bus.Cx      = fp[11];
    assign bus.Sx      = fp[12];
    assign bus.Mx      = fp[13];
    assign bus.Vpostx1 = fp[14];
    assign bus.Wpostx1 = fp[15];
    assign bus.xs      = fp[16];
    assign bus.tanhxs  = fp[17];
    assign bus.ws      = fp[18];
    assign bus.ys      = fp[19];
    assign bus.zs      = fp[20];
    assign bus.ps      = fp[21];
    assign bus.qs      = fp[22];
    assign bus.rs      = fp[23];
    assign bus.RMout   = fp[24];

endmodule

// File: tb/tb_syn_neuron_core.sv
// Randomised and directed bench for syn_neuron_core against an arithmetic reference model.
// The model steps on its own cycle count of the tick schedule.
module tb_syn_neuron_core;

    localparam int TD    = 10;
    localparam int HALF  = TD / 2;
    localparam int TAU   = 4;
    localparam int ONE_I = 32'h0001_0000;

    logic clk_0_1ps = 1'b0;
    logic reset     = 1'b0;

    syn_neuron_core_if bus ();

    syn_neuron_core #(.TICK_DIV(TD)) dut (
        .clk_0_1ps (clk_0_1ps),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_0_1ps = ~clk_0_1ps;

    int checks = 0;
    int errors = 0;

    int m_rm, m_ww, m_ax, m_dx, m_trx, m_prel, m_cx, m_sx, m_v, m_w, m_xn, m_yn, m_rmo;
    bit m_p1, m_p4;
    int edge_n;
    int m_ticks = 0;

    function automatic int m_mul(input int a, input int b);
        longint p;
        p = (longint'(a) * longint'(b)) >>> 16;
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return int'(p);
    endfunction

    function automatic int m_clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic logic [31:0] to_fp(input int q);
        longint      m;
        int          e;
        logic [31:0] mant;
        if (q == 0) return 32'h0;
        m = (q < 0) ? -longint'(q) : longint'(q);
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e >= 23) mant = 32'(m >> (e - 23));
        else         mant = 32'(m << (23 - e));
        return {(q < 0), 8'(127 + e - 16), mant[22:0]};
    endfunction

    task automatic model_reset();
        m_rm = ONE_I; m_rmo = ONE_I; m_ww = 32'h8000; m_prel = 32'h4000;
        m_ax = 0; m_dx = 0; m_trx = 0; m_cx = 0; m_sx = 0;
        m_v = 0; m_w = 0; m_xn = 0; m_yn = 0;
        m_p1 = 1'b0; m_p4 = 1'b0; edge_n = 0;
    endtask

    task automatic model_tick(input logic t1, input logic t4, input logic en);
        bit pre, post;
        int rel, isyn, ww, prel;
        pre  = t1 && !m_p1;
        post = t4 && !m_p4;
        m_p1 = t1;
        m_p4 = t4;
        m_ticks++;
        if (!en) return;
        rel  = pre ? m_mul(m_prel, m_rm) : 0;
        isyn = m_mul(m_ww, m_sx);
        ww   = m_ww + (post ? m_ax : 0) - (pre ? m_dx : 0);
        prel = 32'h4000 + (m_cx >>> 2);
        m_xn  = m_v;
        m_yn  = m_w;
        m_rmo = m_rm;
        m_trx = rel;
        m_rm  = m_rm - rel + ((ONE_I - m_rm) >>> TAU);
        m_ax  = m_ax - (m_ax >>> TAU) + (pre ? 32'h4000 : 0);
        m_dx  = m_dx - (m_dx >>> TAU) + (post ? 32'h2000 : 0);
        m_cx  = m_cx - (m_cx >>> TAU) + (pre ? 32'h8000 : 0);
        m_prel = (prel > ONE_I) ? ONE_I : prel;
        m_ww  = m_clamp(ww, 0, ONE_I);
        m_sx  = m_sx - (m_sx >>> TAU) + rel;
        begin
            int v_old;
            v_old = m_v;
            m_v = m_v + ((isyn - m_v - m_w) >>> TAU);
            m_w = m_w + ((v_old - m_w) >>> TAU);
        end
    endtask

    // First tick lands HALF cycles after reset release, then every TD cycles.
    always @(posedge clk_0_1ps or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            edge_n++;
            if (edge_n % TD == HALF) model_tick(bus.tp1, bus.td4, bus.enable);
        end
    end

    function automatic int exp_q(input int i);
        int ys, zs, ps, qs, rs;
        ys = m_mul(m_v, m_v);
        zs = m_mul(m_v, ys);
        ps = m_mul(zs, 32'h5555);
        qs = m_v - ps;
        rs = m_clamp(qs, -ONE_I, ONE_I);
        case (i)
            0:  return m_mul(m_ww, m_sx);
            1:  return m_rm;
            2:  return m_ww;
            3:  return m_ax;
            4:  return m_dx;
            5:  return m_trx;
            6:  return m_prel;
            7:  return m_sx >>> 1;
            8:  return m_ax - m_dx;
            9:  return m_xn;
            10: return m_yn;
            11: return m_cx;
            12: return m_sx;
            13: return m_mul(m_cx, m_cx);
            14: return m_v;
            15: return m_w;
            16: return m_v;
            17: return rs;
            18: return ONE_I - m_mul(rs, rs);
            19: return ys;
            20: return zs;
            21: return ps;
            22: return qs;
            23: return rs;
            default: return m_rmo;
        endcase
    endfunction

    function automatic logic [31:0] dut_fp(input int i);
        case (i)
            0:  return bus.Isyn1;   1:  return bus.RMx;     2:  return bus.WWx;
            3:  return bus.Ax;      4:  return bus.Dx;      5:  return bus.RMtrx;
            6:  return bus.Prelx;   7:  return bus.Inhx;    8:  return bus.Pxy;
            9:  return bus.Xn;      10: return bus.Yn;      11: return bus.Cx;
            12: return bus.Sx;      13: return bus.Mx;      14: return bus.Vpostx1;
            15: return bus.Wpostx1; 16: return bus.xs;      17: return bus.tanhxs;
            18: return bus.ws;      19: return bus.ys;      20: return bus.zs;
            21: return bus.ps;      22: return bus.qs;      23: return bus.rs;
            default: return bus.RMout;
        endcase
    endfunction

    function automatic string oname(input int i);
        string n [25] = '{"Isyn1", "RMx", "WWx", "Ax", "Dx", "RMtrx", "Prelx", "Inhx", "Pxy",
                          "Xn", "Yn", "Cx", "Sx", "Mx", "Vpostx1", "Wpostx1", "xs", "tanhxs",
                          "ws", "ys", "zs", "ps", "qs", "rs", "RMout"};
        return n[i];
    endfunction

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = m_ticks + n;
        budget = (n + 1) * TD + 2;
        while (m_ticks < target && budget > 0) begin
            @(negedge clk_0_1ps);
            budget--;
        end
        if (m_ticks < target) begin
            checks++;
            errors++;
            $display("FAIL wait_ticks: reached %0d ticks, required %0d", m_ticks, target);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.tp1 = 1'b0;
        bus.td4 = 1'b0;
        repeat (3) @(negedge clk_0_1ps);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int          idx  [6] = '{0, 1, 2, 6, 18, 24};
        logic [31:0] want [6] = '{32'h0, 32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000,
                                  32'h3F80_0000, 32'h3F80_0000};
        reset = 1'b0;
        bus.enable = 1'b1;
        bus.tp1 = 1'b0;
        bus.td4 = 1'b0;
        repeat (3) @(negedge clk_0_1ps);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut_fp(idx[i]) !== want[i]) begin
                errors++;
                $display("FAIL reset_%s got %h want %h", oname(idx[i]), dut_fp(idx[i]), want[i]);
            end
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (dut_fp(i) !== to_fp(exp_q(i))) begin
                errors++;
                $display("FAIL reset_model_%s got %h want %h", oname(i), dut_fp(i), to_fp(exp_q(i)));
            end
        end
    endtask

    task automatic test_single_pre();
        int          idx  [7] = '{3, 11, 5, 1, 12, 2, 0};
        logic [31:0] want [7] = '{32'h3E80_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000,
                                  32'h3E80_0000, 32'h3F00_0000, 32'h3E00_0000};
        do_reset();
        bus.enable = 1'b1;
        bus.tp1 = 1'b1;
        repeat (HALF - 1) @(negedge clk_0_1ps);
        checks++;
        if (bus.Ax !== 32'h0) begin
            errors++;
            $display("FAIL pre_before_tick Ax got %h want %h", bus.Ax, 32'h0);
        end
        @(negedge clk_0_1ps);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dut_fp(idx[i]) !== want[i]) begin
                errors++;
                $display("FAIL pre_%s got %h want %h", oname(idx[i]), dut_fp(idx[i]), want[i]);
            end
        end
    endtask

    task automatic test_single_post();
        do_reset();
        bus.enable = 1'b1;
        bus.td4 = 1'b1;
        wait_ticks(1);
        checks++;
        if (bus.Dx !== 32'h3E00_0000) begin
            errors++;
            $display("FAIL post_Dx got %h want %h", bus.Dx, 32'h3E00_0000);
        end
        checks++;
        if (bus.WWx !== 32'h3F00_0000) begin
            errors++;
            $display("FAIL post_WWx got %h want %h", bus.WWx, 32'h3F00_0000);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.enable = 1'b1;
        bus.tp1 = 1'b1;
        bus.td4 = 1'b1;
        wait_ticks(1);
        bus.tp1 = 1'b0;
        bus.td4 = 1'b0;
        wait_ticks(1);
        bus.tp1 = 1'b1;
        bus.td4 = 1'b1;
        wait_ticks(1);
        checks++;
        if (bus.WWx !== 32'h3F1E_0000) begin
            errors++;
            $display("FAIL simul_WWx got %h want %h", bus.WWx, 32'h3F1E_0000);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (dut_fp(i) !== to_fp(exp_q(i))) begin
                errors++;
                $display("FAIL simul_%s got %h want %h", oname(i), dut_fp(i), to_fp(exp_q(i)));
            end
        end
    endtask

    task automatic test_alternate();
        logic [31:0] prev_ww;
        logic [31:0] ax_peak;
        logic [31:0] dx_peak;
        do_reset();
        bus.enable = 1'b1;
        prev_ww = 32'h3F00_0000;
        for (int k = 0; k < 10; k++) begin
            bus.tp1 = 1'b1;
            wait_ticks(1);
            ax_peak = to_fp(m_ax);
            bus.tp1 = 1'b0;
            wait_ticks(3);
            checks++;
            if (bus.Ax >= ax_peak) begin
                errors++;
                $display("FAIL alt_Ax_decay[%0d] got %h want below %h", k, bus.Ax, ax_peak);
            end
            bus.td4 = 1'b1;
            wait_ticks(1);
            dx_peak = to_fp(m_dx);
            checks++;
            if (bus.WWx < prev_ww || bus.WWx > 32'h3F80_0000) begin
                errors++;
                $display("FAIL alt_WWx[%0d] got %h want in [%h, 3f800000]", k, bus.WWx, prev_ww);
            end
            checks++;
            if (bus.WWx !== to_fp(m_ww)) begin
                errors++;
                $display("FAIL alt_WWx_model[%0d] got %h want %h", k, bus.WWx, to_fp(m_ww));
            end
            prev_ww = to_fp(m_ww);
            bus.td4 = 1'b0;
            wait_ticks(3);
            checks++;
            if (bus.Dx >= dx_peak) begin
                errors++;
                $display("FAIL alt_Dx_decay[%0d] got %h want below %h", k, bus.Dx, dx_peak);
            end
        end
        checks++;
        if (bus.WWx <= 32'h3F00_0000) begin
            errors++;
            $display("FAIL alt_WWx_rise got %h want above %h", bus.WWx, 32'h3F00_0000);
        end
    endtask

    task automatic test_disable();
        do_reset();
        bus.enable = 1'b1;
        bus.tp1 = 1'b1;
        wait_ticks(2);
        bus.enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.tp1 = k[0];
            bus.td4 = ~k[0];
            wait_ticks(1);
            for (int i = 0; i < 25; i++) begin
                checks++;
                if (dut_fp(i) !== to_fp(exp_q(i))) begin
                    errors++;
                    $display("FAIL disable[%0d]_%s got %h want %h", k, oname(i), dut_fp(i), to_fp(exp_q(i)));
                end
            end
        end
        bus.tp1 = 1'b1;
        bus.td4 = 1'b1;
        wait_ticks(1);
        bus.enable = 1'b1;
        wait_ticks(1);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (dut_fp(i) !== to_fp(exp_q(i))) begin
                errors++;
                $display("FAIL reenable_%s got %h want %h", oname(i), dut_fp(i), to_fp(exp_q(i)));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 120; k++) begin
            bus.tp1    = 1'($urandom_range(0, 1));
            bus.td4    = 1'($urandom_range(0, 1));
            bus.enable = ($urandom_range(0, 9) != 0);
            wait_ticks(1);
            for (int i = 0; i < 25; i++) begin
                checks++;
                if (dut_fp(i) !== to_fp(exp_q(i))) begin
                    errors++;
                    $display("FAIL random[%0d]_%s got %h want %h", k, oname(i), dut_fp(i), to_fp(exp_q(i)));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int          idx  [5] = '{1, 2, 6, 3, 0};
        logic [31:0] want [5] = '{32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h0, 32'h0};
        do_reset();
        bus.enable = 1'b1;
        bus.tp1 = 1'b1;
        wait_ticks(3);
        @(posedge clk_0_1ps);
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_fp(idx[i]) !== want[i]) begin
                errors++;
                $display("FAIL async_%s got %h want %h", oname(idx[i]), dut_fp(idx[i]), want[i]);
            end
        end
        @(negedge clk_0_1ps);
        reset = 1'b1;
        wait_ticks(1);
        checks++;
        if (bus.RMx !== 32'h3F40_0000 || bus.Ax !== 32'h3E80_0000) begin
            errors++;
            $display("FAIL async_first_tick RMx/Ax got %h/%h want 3f400000/3e800000", bus.RMx, bus.Ax);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pre();
        test_single_post();
        test_simultaneous();
        test_alternate();
        test_disable();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
